// File: rtl/hyperbus_phy_seq.sv
// HyperBus PHY transaction sequencer: emits CA words, initial latency, write/read data phases and CS hold.
// Optional READ watchdog is compiled in with HYPERBUS_PHY_SEQ_TIMEOUT_EN.
module hyperbus_phy_seq #(
    parameter int NumChips   = 2,
    parameter int BurstWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            cfg_latency_i,
    input  logic                  tf_valid_i,
    output logic                  tf_ready_o,
    input  logic                  tf_write_i,
    input  logic                  tf_reg_i,
    input  logic [31:0]           tf_addr_i,
    input  logic [BurstWidth-1:0] tf_len_i,
    input  logic [NumChips-1:0]   tf_cs_i,
    input  logic [15:0]           wdata_i,
    input  logic [1:0]            wstrb_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    output logic [15:0]           rdata_o,
    output logic                  rdata_valid_o,
    input  logic                  rdata_ready_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [NumChips-1:0]   cs_o,
    output logic                  cs_ena_o,
    output logic                  rwds_sample_ena_o,
    input  logic                  rwds_sample_i,
    output logic                  tx_clk_ena_o,
    output logic [15:0]           tx_data_o,
    output logic                  tx_data_oe_o,
    output logic [1:0]            tx_rwds_o,
    output logic                  tx_rwds_oe_o,
    output logic                  rx_clk_set_o,
    output logic                  rx_clk_reset_o,
    input  logic [15:0]           rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o
);

    typedef enum logic [3:0] {
        IDLE, CA0, CA1, CA2, WAIT, WRITE, READ, HOLD0, HOLD1
    } state_t;

    state_t                state_reg, state_next;
    logic                  write_reg, write_next;
    logic                  regsp_reg, regsp_next;
    logic [31:0]           addr_reg, addr_next;
    logic [BurstWidth-1:0] len_reg, len_next;
    logic [NumChips-1:0]   cs_reg, cs_next;
    logic [3:0]            lat_reg, lat_next;
    logic                  x_reg, x_next;
    logic [4:0]            wait_cnt_reg, wait_cnt_next;
    logic [BurstWidth:0]   word_cnt_reg, word_cnt_next;
    logic                  first_read_reg, first_read_next;
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
    logic [7:0]            to_cnt_reg, to_cnt_next;
    logic                  err_reg, err_next;
`endif

    logic [47:0] ca_word;
    logic [4:0]  lat_eff;
    logic [4:0]  wait_cycles;
    logic        word_done;
    logic        cs_active;
    state_t      data_state;

    assign ca_word     = {~write_reg, regsp_reg, 1'b1, addr_reg[31:3], 13'd0, addr_reg[2:0]};
    assign lat_eff     = (lat_reg < 4'd3) ? 5'd3 : {1'b0, lat_reg};
    // CA takes three of the L clocks, so the remaining latency is (L or 2L) - 3.
    assign wait_cycles = x_reg ? (lat_eff + lat_eff - 5'd3) : (lat_eff - 5'd3);
    assign word_done   = (word_cnt_reg == {1'b0, len_reg});
    assign data_state  = write_reg ? WRITE : READ;
    assign cs_active   = (state_reg != IDLE) && (state_reg != HOLD1);

    generate
        for (genvar gi = 0; gi < NumChips; gi++) begin : g_cs
            assign cs_o[gi] = cs_reg[gi] & cs_active;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            write_reg      <= 1'b0;
            regsp_reg      <= 1'b0;
            addr_reg       <= '0;
            len_reg        <= '0;
            cs_reg         <= '0;
            lat_reg        <= '0;
            x_reg          <= 1'b0;
            wait_cnt_reg   <= '0;
            word_cnt_reg   <= '0;
            first_read_reg <= 1'b0;
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
            to_cnt_reg     <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            write_reg      <= write_next;
            regsp_reg      <= regsp_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            cs_reg         <= cs_next;
            lat_reg        <= lat_next;
            x_reg          <= x_next;
            wait_cnt_reg   <= wait_cnt_next;
            word_cnt_reg   <= word_cnt_next;
            first_read_reg <= first_read_next;
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
            to_cnt_reg     <= to_cnt_next;
            err_reg        <= err_next;
`endif
        end
    end

    always_comb begin
        state_next        = state_reg;
        write_next        = write_reg;
        regsp_next        = regsp_reg;
        addr_next         = addr_reg;
        len_next          = len_reg;
        cs_next           = cs_reg;
        lat_next          = lat_reg;
        x_next            = x_reg;
        wait_cnt_next     = wait_cnt_reg;
        word_cnt_next     = word_cnt_reg;
        first_read_next   = first_read_reg;
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
        to_cnt_next       = to_cnt_reg;
        err_next          = err_reg;
`endif
        tf_ready_o        = 1'b0;
        wdata_ready_o     = 1'b0;
        rdata_o           = 16'd0;
        rdata_valid_o     = 1'b0;
        done_o            = 1'b0;
        err_o             = 1'b0;
        cs_ena_o          = 1'b0;
        rwds_sample_ena_o = 1'b0;
        tx_clk_ena_o      = 1'b0;
        tx_data_o         = 16'd0;
        tx_data_oe_o      = 1'b0;
        tx_rwds_o         = 2'b00;
        tx_rwds_oe_o      = 1'b0;
        rx_clk_set_o      = 1'b0;
        rx_clk_reset_o    = 1'b0;
        rx_ready_o        = 1'b0;

        case (state_reg)
            IDLE: begin
                tf_ready_o = ~rst_i;
                if (tf_valid_i) begin
                    write_next    = tf_write_i;
                    regsp_next    = tf_reg_i;
                    addr_next     = tf_addr_i;
                    len_next      = tf_len_i;
                    cs_next       = tf_cs_i;
                    lat_next      = cfg_latency_i;
                    word_cnt_next = '0;
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
                    err_next      = 1'b0;
`endif
                    state_next    = CA0;
                end
            end
            CA0, CA1, CA2: begin
                cs_ena_o     = 1'b1;
                tx_clk_ena_o = 1'b1;
                tx_data_oe_o = 1'b1;
                if (state_reg == CA0) begin
                    tx_data_o = ca_word[47:32];
                    state_next = CA1;
                end else if (state_reg == CA1) begin
                    tx_data_o         = ca_word[31:16];
                    rwds_sample_ena_o = 1'b1;
                    x_next            = rwds_sample_i;
                    state_next        = CA2;
                end else begin
                    tx_data_o       = ca_word[15:0];
                    first_read_next = 1'b1;
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
                    to_cnt_next     = '0;
`endif
                    if (write_reg && regsp_reg) begin
                        state_next = WRITE;
                    end else if (wait_cycles == 5'd0) begin
                        state_next = data_state;
                    end else begin
                        wait_cnt_next = wait_cycles;
                        state_next    = WAIT;
                    end
                end
            end
            WAIT: begin
                cs_ena_o     = 1'b1;
                tx_clk_ena_o = 1'b1;
                if (wait_cnt_reg == 5'd1) begin
                    state_next = data_state;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 5'd1;
                end
            end
            WRITE: begin
                cs_ena_o     = 1'b1;
                tx_clk_ena_o = 1'b1;
                tx_data_oe_o = 1'b1;
                tx_rwds_oe_o = ~regsp_reg;
                if (wdata_valid_i) begin
                    wdata_ready_o = 1'b1;
                    tx_data_o     = wdata_i;
                    tx_rwds_o     = ~wstrb_i;
                    if (word_done) state_next = HOLD0;
                    else           word_cnt_next = word_cnt_reg + 1'b1;
                end else begin
                    tx_rwds_o = 2'b11;
                end
            end
            READ: begin
                cs_ena_o        = 1'b1;
                tx_clk_ena_o    = 1'b1;
                rx_clk_set_o    = first_read_reg;
                first_read_next = 1'b0;
                rx_ready_o      = rdata_ready_i;
                rdata_o         = rx_data_i;
                rdata_valid_o   = rx_valid_i;
                if (rx_valid_i && rdata_ready_i) begin
                    if (word_done) state_next = HOLD0;
                    else           word_cnt_next = word_cnt_reg + 1'b1;
                end
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
                // The 255th consecutive cycle without rx_valid_i abandons the burst.
                if (rx_valid_i) begin
                    to_cnt_next = '0;
                end else if (to_cnt_reg == 8'd254) begin
                    err_next   = 1'b1;
                    state_next = HOLD0;
                end else begin
                    to_cnt_next = to_cnt_reg + 8'd1;
                end
`endif
            end
            HOLD0: begin
                cs_ena_o       = 1'b1;
                rx_clk_reset_o = 1'b1;
                state_next     = HOLD1;
            end
            HOLD1: begin
                done_o     = 1'b1;
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
                err_o      = err_reg;
`endif
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hyperbus_phy_seq.sv
// Directed bench for hyperbus_phy_seq: read/write/register transfers, latency boundaries, reset abort.
module tb_hyperbus_phy_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  cfg_latency_i;
    logic        tf_valid_i, tf_ready_o, tf_write_i, tf_reg_i;
    logic [31:0] tf_addr_i;
    logic [7:0]  tf_len_i;
    logic [1:0]  tf_cs_i;
    logic [15:0] wdata_i;
    logic [1:0]  wstrb_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [15:0] rdata_o;
    logic        rdata_valid_o, rdata_ready_i, done_o, err_o;
    logic [1:0]  cs_o;
    logic        cs_ena_o, rwds_sample_ena_o, rwds_sample_i, tx_clk_ena_o;
    logic [15:0] tx_data_o;
    logic        tx_data_oe_o;
    logic [1:0]  tx_rwds_o;
    logic        tx_rwds_oe_o, rx_clk_set_o, rx_clk_reset_o;
    logic [15:0] rx_data_i;
    logic        rx_valid_i, rx_ready_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    hyperbus_phy_seq #(.NumChips(2), .BurstWidth(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_latency_i(cfg_latency_i),
        .tf_valid_i(tf_valid_i), .tf_ready_o(tf_ready_o), .tf_write_i(tf_write_i),
        .tf_reg_i(tf_reg_i), .tf_addr_i(tf_addr_i), .tf_len_i(tf_len_i), .tf_cs_i(tf_cs_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .rdata_ready_i(rdata_ready_i), .done_o(done_o), .err_o(err_o), .cs_o(cs_o),
        .cs_ena_o(cs_ena_o), .rwds_sample_ena_o(rwds_sample_ena_o),
        .rwds_sample_i(rwds_sample_i), .tx_clk_ena_o(tx_clk_ena_o), .tx_data_o(tx_data_o),
        .tx_data_oe_o(tx_data_oe_o), .tx_rwds_o(tx_rwds_o), .tx_rwds_oe_o(tx_rwds_oe_o),
        .rx_clk_set_o(rx_clk_set_o), .rx_clk_reset_o(rx_clk_reset_o),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_txn(input logic [3:0] lat, input logic x, input int exp_wait,
                            input int len, input logic [31:0] addr,
                            input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
        int n, beats, cyc;
        logic [15:0] d;
        cfg_latency_i = lat; tf_valid_i = 1'b1; tf_write_i = 1'b0; tf_reg_i = 1'b0;
        tf_addr_i = addr; tf_len_i = len[7:0]; tf_cs_i = 2'b10;
        #1 chk("idle_ready", tf_ready_o, 1);
        @(posedge clk_i); #1 tf_valid_i = 1'b0; #1;
        chk("ca0_data", tx_data_o, c0);
        chk("ca0_cs", cs_o, 2'b10);
        chk("ca0_ctl", {tx_data_oe_o, tx_clk_ena_o, cs_ena_o, rwds_sample_ena_o}, 4'b1110);
        @(posedge clk_i); #1 rwds_sample_i = x; #1;
        chk("ca1_data", tx_data_o, c1);
        chk("ca1_sample", rwds_sample_ena_o, 1);
        @(posedge clk_i); #1 rwds_sample_i = 1'b0; #1;
        chk("ca2_data", tx_data_o, c2);
        chk("ca2_sample", rwds_sample_ena_o, 0);
        n = 0;
        @(posedge clk_i); #2;
        while (!rx_clk_set_o && n < 40) begin
            if (n == 0) chk("wait_ctl", {tx_data_oe_o, tx_clk_ena_o, cs_ena_o}, 3'b011);
            n++;
            @(posedge clk_i); #2;
        end
        chk("wait_cycles", n, exp_wait);
        beats = 0; cyc = 0;
        while (beats <= len && cyc < 2000) begin
            d = 16'h1000 + 16'(beats);
            rx_data_i     = d;
            rx_valid_i    = (cyc != 2);
            rdata_ready_i = (cyc != 1);
            #1;
            chk("rx_set", rx_clk_set_o, cyc == 0);
            chk("rdata", rdata_o, d);
            chk("rvalid", rdata_valid_o, cyc != 2);
            chk("rx_ready", rx_ready_o, cyc != 1);
            if (cyc != 1 && cyc != 2) beats++;
            cyc++;
            @(posedge clk_i); #1;
        end
        rx_valid_i = 1'b0; rdata_ready_i = 1'b1; #1;
        chk("rd_hold0", {rx_clk_reset_o, tx_clk_ena_o, cs_ena_o, done_o}, 4'b1010);
        chk("rd_hold0_cs", cs_o, 2'b10);
        @(posedge clk_i); #2;
        chk("rd_done", {done_o, err_o, cs_ena_o}, 3'b100);
        chk("rd_hold1_cs", cs_o, 2'b00);
        @(posedge clk_i); #2;
        chk("rd_back_idle", {tf_ready_o, done_o}, 2'b10);
    endtask

    initial begin
        bit seen_done;
        int n;
        rst_i = 1'b1; cfg_latency_i = 4'd6; tf_valid_i = 1'b0; tf_write_i = 1'b0;
        tf_reg_i = 1'b0; tf_addr_i = '0; tf_len_i = '0; tf_cs_i = '0; wdata_i = '0;
        wstrb_i = '0; wdata_valid_i = 1'b0; rdata_ready_i = 1'b1; rwds_sample_i = 1'b0;
        rx_data_i = '0; rx_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_outputs", {tf_ready_o, cs_ena_o, tx_clk_ena_o, tx_data_oe_o, done_o, cs_o}, 7'd0);
        rst_i = 1'b0; #1;
        chk("post_rst_ready", tf_ready_o, 1);

        read_txn(4'd6, 1'b0, 3, 3, 32'h100, 16'hA000, 16'h0020, 16'h0000);
        read_txn(4'd6, 1'b1, 9, 3, 32'h100, 16'hA000, 16'h0020, 16'h0000);

        // Register write, then a memory write requested during HOLD1
        tf_valid_i = 1'b1; tf_write_i = 1'b1; tf_reg_i = 1'b1; tf_addr_i = 32'h0;
        tf_len_i = 8'd0; tf_cs_i = 2'b01;
        @(posedge clk_i); #1 tf_valid_i = 1'b0; #1;
        chk("rw_ca0", tx_data_o, 16'h6000);
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("rw_ca2", tx_data_o, 16'h0000);
        @(posedge clk_i); #1 wdata_valid_i = 1'b1; wdata_i = 16'h8F1F; wstrb_i = 2'b11; #1;
        chk("rw_data", tx_data_o, 16'h8F1F);
        chk("rw_ctl", {tx_data_oe_o, tx_rwds_oe_o, wdata_ready_o}, 3'b101);
        @(posedge clk_i); #1 wdata_valid_i = 1'b0; #1;
        chk("rw_hold0", {tx_clk_ena_o, cs_ena_o, tx_data_oe_o, rx_clk_reset_o}, 4'b0101);
        @(posedge clk_i); #1;
        tf_valid_i = 1'b1; tf_write_i = 1'b1; tf_reg_i = 1'b0; tf_addr_i = 32'h10;
        tf_len_i = 8'd1; tf_cs_i = 2'b01; #1;
        chk("rw_done", {done_o, err_o}, 2'b10);
        chk("hold1_no_accept", tf_ready_o, 0);
        @(posedge clk_i); #2;
        chk("idle_accept", tf_ready_o, 1);
        @(posedge clk_i); #1 tf_valid_i = 1'b0; #1;
        chk("mw_ca0", tx_data_o, 16'h2000);
        @(posedge clk_i); #2;
        chk("mw_ca1", tx_data_o, 16'h0002);
        @(posedge clk_i); n = 0;
        @(posedge clk_i); #2;
        while (!tx_data_oe_o && n < 40) begin n++; @(posedge clk_i); #2; end
        chk("mw_wait", n, 3);
        wdata_valid_i = 1'b1; wdata_i = 16'hAAAA; wstrb_i = 2'b01; #1;
        chk("mw_w0", {tx_data_o, tx_rwds_o, tx_rwds_oe_o, wdata_ready_o}, {16'hAAAA, 2'b10, 2'b11});
        @(posedge clk_i); #1 wdata_valid_i = 1'b0; #1;
        chk("mw_mask", {tx_rwds_o, tx_data_oe_o, tx_rwds_oe_o, wdata_ready_o}, 5'b11110);
        @(posedge clk_i); #1 wdata_valid_i = 1'b1; wdata_i = 16'h5555; wstrb_i = 2'b11; #1;
        chk("mw_w1", {tx_data_o, tx_rwds_o, wdata_ready_o}, {16'h5555, 2'b00, 1'b1});
        @(posedge clk_i); #1 wdata_valid_i = 1'b0; #1;
        chk("mw_hold0", {tx_clk_ena_o, tx_data_oe_o, tx_rwds_oe_o, cs_ena_o}, 4'b0001);
        @(posedge clk_i); #2;
        chk("mw_done", {done_o, err_o}, 2'b10);
        @(posedge clk_i); #2;

        // Latency clamp, high address bits, and a full 256-word burst
        read_txn(4'd1, 1'b0, 0, 0, 32'hFFFF_FFFF, 16'hBFFF, 16'hFFFF, 16'h0007);
        read_txn(4'd2, 1'b1, 3, 1, 32'hFFFF_FFFF, 16'hBFFF, 16'hFFFF, 16'h0007);
        read_txn(4'd15, 1'b1, 27, 255, 32'h10, 16'hA000, 16'h0002, 16'h0000);

        // Reset while waiting out the latency
        cfg_latency_i = 4'd6; tf_valid_i = 1'b1; tf_write_i = 1'b0; tf_addr_i = 32'h0;
        tf_len_i = 8'd3; tf_cs_i = 2'b11;
        @(posedge clk_i); #1 tf_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("abort_in_wait", {tx_clk_ena_o, cs_ena_o, tx_data_oe_o}, 3'b110);
        rst_i = 1'b1;
        @(posedge clk_i); #2;
        chk("abort_outputs", {cs_ena_o, tx_clk_ena_o, tx_data_oe_o, tx_rwds_oe_o, tf_ready_o}, 5'd0);
        chk("abort_cs", cs_o, 2'b00);
        rst_i = 1'b0; #1;
        chk("abort_ready", tf_ready_o, 1);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #2;
            if (done_o || tx_clk_ena_o) seen_done = 1'b1;
        end
        chk("abort_quiet", seen_done, 0);

`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
        cfg_latency_i = 4'd3; tf_valid_i = 1'b1; tf_len_i = 8'd0; tf_cs_i = 2'b01;
        @(posedge clk_i); #1 tf_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2; n = 0;
        while (!rx_clk_reset_o && n < 400) begin n++; @(posedge clk_i); #2; end
        chk("to_read_cycles", n, 255);
        @(posedge clk_i); #2;
        chk("to_done_err", {done_o, err_o}, 2'b11);
        @(posedge clk_i); #2;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hyperbus_phy_seq.md
HYPERBUS_PHY_SEQ -- requirements
Module: hyperbus_phy_seq

Interface
REQ-001 SHALL have parameter NumChips, default 2, number of chip selects.
REQ-002 SHALL have parameter BurstWidth, default 8, width of burst length field.
REQ-003 SHALL have one clock and one synchronous active-high reset: clk_i and rst_i.
REQ-004 clk_i  in  1  PHY clock; every flop is on its rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 cfg_latency_i  in  4  initial latency L in clocks; values below 3 treated as 3.
REQ-007 tf_valid_i/tf_ready_o  in/out  1  transfer request handshake.
REQ-008 tf_write_i  in  1, tf_reg_i  in  1, tf_addr_i  in  32, tf_len_i  in  BurstWidth (words minus 1), tf_cs_i  in  NumChips.
REQ-009 wdata_i  in  16, wstrb_i  in  2, wdata_valid_i/wdata_ready_o  in/out  1.
REQ-010 rdata_o  out  16, rdata_valid_o  out  1, rdata_ready_i  in  1.
REQ-011 done_o  out  1  one-cycle completion pulse; err_o  out  1  qualified by done_o.
REQ-012 Transceiver side: cs_o, cs_ena_o, rwds_sample_ena_o, rwds_sample_i, tx_clk_ena_o, tx_data_o[15:0], tx_data_oe_o, tx_rwds_o[1:0], tx_rwds_oe_o, rx_clk_set_o, rx_clk_reset_o, rx_data_i[15:0], rx_valid_i, rx_ready_o.

Function
REQ-013 SHALL implement states IDLE, CA0, CA1, CA2, WAIT, WRITE, READ, HOLD0, HOLD1.
REQ-014 IDLE: tf_ready_o=1; on tf_valid_i, capture request and go to CA0.
REQ-015 CA word: [47]=~tf_write_i, [46]=tf_reg_i, [45]=1 (linear), [44:16]=addr[31:3], [15:3]=0, [2:0]=addr[2:0].
REQ-016 CA0/CA1/CA2 drive CA[47:32]/[31:16]/[15:0] on tx_data_o with tx_data_oe_o=1, tx_clk_ena_o=1, cs_ena_o=1.
REQ-017 rwds_sample_ena_o SHALL be 1 in CA1 only; the sampled value sets extra-latency flag X.
REQ-018 Register write (tf_reg_i=1, tf_write_i=1) SHALL skip WAIT: CA2 -> WRITE with tx_rwds_oe_o=0.
REQ-019 Otherwise WAIT lasts (X ? 2L : L) - 3 cycles (0 cycles legal), clock running, data OE off; then WRITE or READ.
REQ-020 WRITE: tx_data_oe_o=1, tx_rwds_oe_o=1; if wdata_valid_i, wdata_ready_o=1, drive wdata_i, tx_rwds_o=~wstrb_i, count word; else drive tx_rwds_o=2'b11 (masked), word not counted.
REQ-021 WRITE exits to HOLD0 after tf_len_i+1 counted words.
REQ-022 READ: rx_clk_set_o=1 on first cycle; rx_ready_o=rdata_ready_i; rdata_o/rdata_valid_o pass rx_data_i/rx_valid_i; exits after tf_len_i+1 rx_valid_i&rx_ready_o beats.
REQ-023 HOLD0: tx_clk_ena_o=0, cs_ena_o=1, rx_clk_reset_o=1; HOLD1: cs_ena_o=0, done_o=1; then IDLE.
REQ-024 cs_o SHALL equal captured tf_cs_i from CA0 through HOLD0, else 0.
REQ-025 Word counter SHALL be BurstWidth+1 bits; tf_len_i all-ones SHALL not wrap.
REQ-026 tf_valid_i arriving in HOLD1 SHALL be accepted no earlier than the following IDLE cycle.

Reset
REQ-027 On rst_i, state=IDLE and all outputs 0 except tf_ready_o which becomes 1 in the first post-reset cycle.
REQ-028 rst_i mid-transfer SHALL abort immediately: CS, clock enable and OEs low next cycle; no done_o.

Configuration
REQ-029 Macro HYPERBUS_PHY_SEQ_TIMEOUT_EN: when defined, an 8-bit counter, cleared per beat, aborts READ after 255 cycles without rx_valid_i, going to HOLD0 with err_o=1 at done_o.
REQ-030 Without HYPERBUS_PHY_SEQ_TIMEOUT_EN, READ waits indefinitely and err_o is tied 0.

Verification
REQ-031 Read, L=6, rwds_sample_i=0, len=3, addr=0x100 -> CA0=0xA000, CA1=0x0020, CA2=0x0000, WAIT 3 cycles, 4 rdata beats, done_o, err_o=0.
REQ-032 Same read with rwds_sample_i=1 in CA1 -> WAIT 9 cycles.
REQ-033 Register write addr=0x0 data=0x8F1F -> CA0=0x6000, no WAIT, one WRITE cycle with tx_rwds_oe_o=0.
REQ-034 Memory write len=1 with wdata_valid_i low one cycle mid-burst -> one masked cycle (tx_rwds_o=2'b11), 3 WRITE cycles total.
REQ-035 rst_i asserted in WAIT -> cs_ena_o, tx_clk_ena_o 0 next cycle, no done_o, IDLE.
REQ-036 With TIMEOUT_EN, read with rx_valid_i never asserted -> done_o with err_o=1 after 255 idle READ cycles.
